// File: rtl/vector_memory_sequencer.sv
// -----------------------------------------------------------------------------
// vector_memory_sequencer
//
// Memory-stage controller that turns one 128-bit vector store or load into
// LANES consecutive byte accesses on a byte-wide data memory. The upstream
// pipeline is frozen while the sequence runs. A load returns the assembled
// vector to writeback together with a one-cycle load_valid pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start_store  vector store request (held by the pipeline while stalled)
//   start_load   vector load request  (held by the pipeline while stalled)
//   base_addr    vector base byte address
//   store_data   vector to store, lane i = bits [8i+7:8i]
//   mem_addr     data memory byte address
//   mem_wdata    data memory write byte
//   mem_we       data memory write enable
//   mem_re       data memory read enable
//   mem_rdata    data memory read byte, valid one cycle after mem_re
//   load_data    last completed load vector
//   load_valid   one-cycle pulse, load_data holds a freshly completed load
//   stall        freeze pipeline registers up to and including execute/memory
//
// Handshake: a request is start_store/start_load high. It is accepted in the
// first IDLE cycle in which it is seen; stall rises combinationally in that
// same cycle and stays high until the sequence finishes. The DONE cycle is the
// release cycle: stall is low, the pipeline advances, and any start_* still
// high in DONE is ignored. A request still present in the following (IDLE)
// cycle is treated as a new operation.
// -----------------------------------------------------------------------------
module vector_memory_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_store,
  input  logic                        start_load,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [LANES*LANE_WIDTH-1:0] store_data,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [LANE_WIDTH-1:0]       mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [LANE_WIDTH-1:0]       mem_rdata,
  output logic [LANES*LANE_WIDTH-1:0] load_data,
  output logic                        load_valid,
  output logic                        stall
);

  localparam int VEC_WIDTH = LANES * LANE_WIDTH;
  localparam int CW        = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [CW-1:0]         lane_q,      lane_d;
  logic                  is_load_q,   is_load_d;
  logic [ADDR_WIDTH-1:0] base_q,      base_d;
  logic [VEC_WIDTH-1:0]  vec_q,       vec_d;
  logic [VEC_WIDTH-1:0]  load_data_q, load_data_d;

  // Registered outputs
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [LANE_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic                  mem_we_q,     mem_we_d;
  logic                  mem_re_q,     mem_re_d;
  logic                  load_valid_q, load_valid_d;

  // Lane that the byte currently on mem_rdata belongs to while in LOAD.
  logic [CW-1:0] prev_lane;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    is_load_d   = is_load_q;
    base_d      = base_q;
    vec_d       = vec_q;
    load_data_d = load_data_q;
    prev_lane   = lane_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        // Store has priority when both requests arrive together.
        if (start_store) begin
          state_d   = S_STORE;
          lane_d    = '0;
          is_load_d = 1'b0;
          base_d    = base_addr;
          vec_d     = store_data;
        end else if (start_load) begin
          state_d   = S_LOAD;
          lane_d    = '0;
          is_load_d = 1'b1;
          base_d    = base_addr;
        end
      end

      S_STORE: begin
        if (lane_q == LAST_LANE) begin
          state_d = S_DONE;
          lane_d  = '0;
        end else begin
          lane_d  = lane_q + CW'(1);
        end
      end

      S_LOAD: begin
        // Read data lags the read strobe by one cycle, so the byte arriving
        // now belongs to the previous lane. Lane 0 has nothing to capture yet.
        if (lane_q != '0) begin
          load_data_d[int'(prev_lane)*LANE_WIDTH +: LANE_WIDTH] = mem_rdata;
        end
        if (lane_q == LAST_LANE) begin
          state_d = S_DRAIN;
          lane_d  = '0;
        end else begin
          lane_d  = lane_q + CW'(1);
        end
      end

      S_DRAIN: begin
        // Last read byte arrives one cycle after the final read strobe.
        load_data_d[int'(LAST_LANE)*LANE_WIDTH +: LANE_WIDTH] = mem_rdata;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output precomputation: the memory port is driven from flops, so its next
  // value is derived from the next state and next lane. Address arithmetic
  // wraps naturally at 2**ADDR_WIDTH through truncation.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we_d     = (state_d == S_STORE);
    mem_re_d     = (state_d == S_LOAD);
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    load_valid_d = (state_d == S_DONE) && is_load_d;

    if (mem_we_d || mem_re_d) begin
      mem_addr_d = base_d + ADDR_WIDTH'(lane_d);
    end
    if (mem_we_d) begin
      mem_wdata_d = vec_d[int'(lane_d)*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      is_load_q    <= 1'b0;
      base_q       <= '0;
      vec_q        <= '0;
      load_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      is_load_q    <= is_load_d;
      base_q       <= base_d;
      vec_q        <= vec_d;
      load_data_q  <= load_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      load_valid_q <= load_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;

  // Combinational so the pipeline freezes in the request cycle itself.
  // Held low during reset so a pending request cannot freeze the pipeline.
  assign stall = !reset &&
                 (((state_q == S_IDLE) && (start_store || start_load)) ||
                  (state_q == S_STORE) || (state_q == S_LOAD) ||
                  (state_q == S_DRAIN));

endmodule

// File: tb/tb_vector_memory_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for vector_memory_sequencer: table of directed vectors, hand-written
// reset-abort and held-request sequences, then randomized operations checked
// against a byte-array model of the data memory.
// -----------------------------------------------------------------------------
module tb_vector_memory_sequencer;

  localparam int AW = 12;
  localparam int VW = 128;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_store;
  logic          start_load;
  logic [AW-1:0] base_addr;
  logic [VW-1:0] store_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata = 8'h00;
  logic [VW-1:0] load_data;
  logic          load_valid;
  logic          stall;

  vector_memory_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start_store(start_store),
    .start_load (start_load),
    .base_addr  (base_addr),
    .store_data (store_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .load_valid (load_valid),
    .stall      (stall)
  );

  // ---------------------------------------------------------------------------
  // Data memory (device) and reference image (model)
  // ---------------------------------------------------------------------------
  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [VW-1:0] last_load;
  logic [21:0]   exp_q[$];   // {we, re, addr, wdata} per access cycle

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== ref_mem[a]) d++;
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one vector operation, called just after a falling edge. Builds the
  // expected access list and result from the byte-array model, then follows
  // the DUT cycle by cycle until stall drops (the DONE cycle).
  // ---------------------------------------------------------------------------
  task automatic run_op(input bit st, input bit ld, input logic [AW-1:0] base,
                        input logic [VW-1:0] data, input bit hold,
                        output int obs_stall, output bit obs_valid,
                        output logic [VW-1:0] obs_load);
    bit            do_store;
    bit            do_load;
    bit            fin;
    int            c;
    logic [VW-1:0] exp_val;
    logic [AW-1:0] a;
    logic [21:0]   e;
    do_store = st;
    do_load  = !st && ld;
    exp_val  = '0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      a = base + AW'(k);
      if (do_store) begin
        exp_q.push_back({1'b1, 1'b0, a, data[8*k +: 8]});
        ref_mem[a] = data[8*k +: 8];
      end else begin
        exp_q.push_back({1'b0, 1'b1, a, 8'h00});
        exp_val[8*k +: 8] = ref_mem[a];
      end
    end

    start_store = st;
    start_load  = ld;
    base_addr   = base;
    store_data  = data;
    #1;
    check("req_stall", stall, 1'b1);
    check("req_load_data", load_data, last_load);

    obs_stall = 1;
    c   = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      c++;
      if (!stall) begin
        fin = 1;
      end else if (c > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: stall still high after %0d cycles", c);
        fin = 1;
      end else begin
        obs_stall++;
        if (c <= 16) begin
          e = exp_q.pop_front();
          check("access", {mem_we, mem_re, mem_addr, mem_wdata}, e);
        end else begin
          check("drain_quiet", {mem_we, mem_re, mem_addr, mem_wdata}, 22'h0);
        end
        check("valid_low", load_valid, 1'b0);
        if (do_store || c <= 2) check("load_data_hold", load_data, last_load);
      end
    end

    obs_valid = load_valid;
    obs_load  = load_data;
    check("access_count", exp_q.size(), 0);
    check("stall_cycles", obs_stall, do_store ? 17 : 18);
    check("done_valid", load_valid, do_load);
    check("done_quiet", {mem_we, mem_re, mem_addr, mem_wdata}, 22'h0);
    if (do_load) begin
      check("load_result", load_data, exp_val);
      last_load = exp_val;
    end else begin
      check("load_data_kept", load_data, last_load);
    end
    check("mem_image", mem_diffs(), 0);
    if (!hold) begin
      start_store = 1'b0;
      start_load  = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, {stall, load_valid, mem_we, mem_re}, 4'b0000);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            st;
    bit            ld;
    logic [AW-1:0] base;
    logic [VW-1:0] data;
    int            exp_stall;
    bit            exp_valid;
    logic [VW-1:0] exp_load;
  } vec_t;

  vec_t          tbl [7];
  int            obs_stall;
  bit            obs_valid;
  logic [VW-1:0] obs_load;
  logic [VW-1:0] rd;
  logic [AW-1:0] ra;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start_store = 1'b0;
    start_load  = 1'b0;
    base_addr   = '0;
    store_data  = '0;
    last_load   = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      mem[12'h200 + k]               = 8'(8'hA0 + k);
      mem[12'(12'hFF8 + 12'(k))]     = 8'(8'h30 + k);
    end
    for (int a = 0; a < 4096; a++) ref_mem[a] = mem[a];

    tbl[0] = '{1'b1, 1'b0, 12'h100, 128'h0F0E0D0C0B0A09080706050403020100, 17, 1'b0, 128'h0};
    tbl[1] = '{1'b0, 1'b1, 12'h200, 128'h0, 18, 1'b1, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
    tbl[2] = '{1'b0, 1'b1, 12'hFF8, 128'h0, 18, 1'b1, 128'h3F3E3D3C3B3A39383736353433323130};
    tbl[3] = '{1'b1, 1'b1, 12'h300, 128'h0123456789ABCDEFFEDCBA9876543210, 17, 1'b0,
               128'h3F3E3D3C3B3A39383736353433323130};
    tbl[4] = '{1'b0, 1'b1, 12'h300, 128'h0, 18, 1'b1, 128'h0123456789ABCDEFFEDCBA9876543210};
    tbl[5] = '{1'b1, 1'b0, 12'hFFC, 128'hDEADBEEFCAFEF00D123456789ABCDEF0, 17, 1'b0,
               128'h0123456789ABCDEFFEDCBA9876543210};
    tbl[6] = '{1'b0, 1'b1, 12'hFFC, 128'h0, 18, 1'b1, 128'hDEADBEEFCAFEF00D123456789ABCDEF0};

    // Reset values, including stall held low while reset is high.
    repeat (3) @(negedge clk);
    check("rst_outputs", {stall, load_valid, mem_we, mem_re, mem_addr, mem_wdata}, 24'h0);
    check("rst_load_data", load_data, 128'h0);
    start_store = 1'b1;
    #1;
    check("rst_stall_gated", stall, 1'b0);
    start_store = 1'b0;
    reset = 1'b0;
    check_idle("post_reset_idle");

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].st, tbl[i].ld, tbl[i].base, tbl[i].data, 1'b0,
             obs_stall, obs_valid, obs_load);
      check("tbl_stall", obs_stall, tbl[i].exp_stall);
      check("tbl_valid", obs_valid, tbl[i].exp_valid);
      check("tbl_load", obs_load, tbl[i].exp_load);
      check_idle("tbl_idle_after");
    end

    // Reset after the fifth store write: lanes 0..4 land, nothing more.
    rd          = {$urandom, $urandom, $urandom, $urandom};
    start_store = 1'b1;
    base_addr   = 12'h100;
    store_data  = rd;
    #1;
    check("abort_req_stall", stall, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ra = 12'h100 + AW'(k);
      check("abort_access", {mem_we, mem_re, mem_addr, mem_wdata},
            {1'b1, 1'b0, ra, rd[8*k +: 8]});
      ref_mem[ra] = rd[8*k +: 8];
    end
    reset       = 1'b1;
    start_store = 1'b0;
    @(negedge clk);
    check("abort_outputs", {stall, load_valid, mem_we, mem_re, mem_addr, mem_wdata}, 24'h0);
    check("abort_load_data", load_data, 128'h0);
    last_load = '0;
    reset = 1'b0;
    check_idle("abort_idle");
    check("abort_mem_image", mem_diffs(), 0);

    // start_load held through DONE and into the next cycle: one load, then a
    // second one whose request cycle is the cycle right after DONE.
    run_op(1'b0, 1'b1, 12'h200, 128'h0, 1'b1, obs_stall, obs_valid, obs_load);
    @(negedge clk);
    run_op(1'b0, 1'b1, 12'hFF8, 128'h0, 1'b0, obs_stall, obs_valid, obs_load);
    check_idle("held_idle_after");

    // Randomized operations against the memory model.
    for (int n = 0; n < 24; n++) begin
      bit st;
      bit ld;
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      ra = (n % 4 == 0) ? AW'($urandom_range(4081, 4095)) : AW'($urandom_range(0, 4095));
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_op(st, ld, ra, rd, 1'b0, obs_stall, obs_valid, obs_load);
      check_idle("rand_idle_after");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_memory_sequencer.md
# vector_memory_sequencer

Memory-stage controller that moves a 128-bit vector between the execute/memory pipeline register and the byte-wide data memory. It serialises one vector store or load into 16 byte accesses, stalls the pipeline while it runs, and returns the assembled 128-bit load result to writeback. It sits between the memory-stage outputs (vector data, 12-bit vector address, vector write/read enables) and the data memory port.

## Interface
- ADDR_WIDTH, 12, data memory byte-address width
- LANES, 16, bytes per vector
- LANE_WIDTH, 8, bits per lane; vector width = LANES*LANE_WIDTH = 128
---
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start_store  in  1  vector store request from memory stage; held while stalled
- start_load  in  1  vector load request from memory stage; held while stalled
- base_addr  in  ADDR_WIDTH  vector base byte address
- store_data  in  128  vector to store; lane i = bits [8i+7:8i]
- mem_addr  out  ADDR_WIDTH  data memory address
- mem_wdata  out  8  data memory write byte
- mem_we  out  1  data memory write enable
- mem_re  out  1  data memory read enable
- mem_rdata  in  8  read data, valid one cycle after mem_re
- load_data  out  128  assembled load vector
- load_valid  out  1  one-cycle pulse: load_data holds a completed load
- stall  out  1  freeze pipeline registers upstream of and including execute/memory

## Operation
- States: IDLE, STORE, LOAD, DRAIN, DONE; 4-bit lane counter i.
- IDLE: if start_store -> latch base_addr, store_data; i=0; go STORE. Else if start_load -> latch base_addr; i=0; go LOAD. Both high: store wins, load ignored.
- STORE: mem_we=1, mem_addr=base+i, mem_wdata=lane i; i increments; after i=15 go DONE.
- LOAD: mem_re=1, mem_addr=base+i; i increments; after i=15 go DRAIN. Each cycle after the first, capture mem_rdata into lane i-1 of load_data.
- DRAIN: capture lane 15; go DONE.
- DONE: stall=0; load_valid=1 if op was a load; start_* ignored this cycle (the pipeline advances on it); go IDLE.
- Address arithmetic modulo 2^ADDR_WIDTH: base 0xFF8 wraps to 0x000 at lane 8. No error flag.
- load_data: register, holds last completed load until the next load's first capture; partially updated only during LOAD/DRAIN.
- mem_we, mem_re, mem_wdata, mem_addr are 0 outside STORE/LOAD.

## Timing
- stall = (IDLE and (start_store or start_load)) or state in {STORE, LOAD, DRAIN}; combinational, so the pipeline freezes in the request cycle.
- Store: 1 request cycle + 16 write cycles stalled = 17 stall cycles; DONE unstalled.
- Load: 1 + 16 + 1 (DRAIN) = 18 stall cycles; load_valid and final load_data in DONE.
- Held start while in DONE does not retrigger. A new request is accepted in IDLE in the cycle after DONE, so back-to-back ops carry a 1-cycle unstalled gap.
- Reset: state IDLE, i=0, latches 0, load_data=0, load_valid=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, stall=0 while reset high.
- Reset mid-operation aborts at the next edge. Bytes already written stay written. No further memory accesses. No load_valid.

## Test plan
- Store base 0x100, data 0x0F0E..0100 -> writes 0x100..0x10F with bytes 0x00..0x0F in order, stall high 17 cycles, no load_valid.
- Memory preloaded 0xA0+k at 0x200+k; load base 0x200 -> 16 reads, load_valid pulse on cycle 19, load_data = 0xAFAE..A1A0, stall 18 cycles.
- Load base 0xFF8 -> addresses 0xFF8..0xFFF then 0x000..0x007; lanes assembled in that order.
- start_store and start_load high together -> store sequence only, mem_re never asserted.
- Reset asserted after 5th store write -> mem_we low next cycle, state IDLE, only 0x100..0x104 modified.
- start_load held high through DONE and one extra cycle -> exactly one load, then a second load starting the cycle after DONE; load_data unchanged until its first capture.
